// File: rtl/prbs_wave_gen.sv
// prbs_wave_gen: PN7..PN31 pseudo-random bit source.
// The bit rate comes from a phase-accumulator NCO. Each bit selects one of two
// signed DAC levels: dc_offset +/- amplitude, saturated to the DAC range.
// Optional feature macro: PRBS_EDGE_RAMP_EN. When it is defined, level changes
// ramp over about 2^edge_shift cycles. When it is undefined, the output steps
// to the new level in one cycle and edge_shift is stored but has no effect.
module prbs_wave_gen #(
  parameter int DAC_W = 16,
  parameter int NCO_W = 32
) (
  input  logic             dac_clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [3:0]       cfg_pn_sel,
  input  logic [NCO_W-1:0] cfg_rate_inc,
  input  logic [3:0]       cfg_edge_shift,
  input  logic [DAC_W-1:0] cfg_amplitude,
  input  logic [DAC_W-1:0] cfg_dc_offset,
  output logic             prbs_valid,
  output logic             bit_strobe,
  output logic             prbs_bit,
  output logic [DAC_W-1:0] dac_data
);

  localparam int LW = 31;         // longest supported LFSR (PN31)
  localparam int EW = DAC_W + 2;  // headroom for dc_offset +/- amplitude

  localparam logic signed [EW-1:0] SAT_MAX = {3'b000, {(DAC_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {3'b111, {(DAC_W-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Active-length mask plus the two Fibonacci tap positions (bit indices).
  typedef struct packed {
    logic [LW-1:0] mask;
    logic [4:0]    hi;
    logic [4:0]    lo;
  } poly_t;

  // Polynomial table. Selects 7..15 fall back to PN7.
  function automatic poly_t poly_of(input logic [3:0] sel);
    poly_t p;
    p.mask = 31'h0000_007F; p.hi = 5'd6; p.lo = 5'd5;          // x^7+x^6+1
    case (sel)
      4'd1: begin p.mask = 31'h0000_01FF; p.hi = 5'd8;  p.lo = 5'd4;  end
      4'd2: begin p.mask = 31'h0000_07FF; p.hi = 5'd10; p.lo = 5'd8;  end
      4'd3: begin p.mask = 31'h0000_7FFF; p.hi = 5'd14; p.lo = 5'd13; end
      4'd4: begin p.mask = 31'h000F_FFFF; p.hi = 5'd19; p.lo = 5'd2;  end
      4'd5: begin p.mask = 31'h007F_FFFF; p.hi = 5'd22; p.lo = 5'd17; end
      4'd6: begin p.mask = 31'h7FFF_FFFF; p.hi = 5'd30; p.lo = 5'd27; end
      default: ;
    endcase
    return p;
  endfunction

  // The seed is all-ones over the active length, which is exactly the mask.
  function automatic logic [LW-1:0] seed_of(input logic [3:0] sel);
    poly_t p;
    p = poly_of(sel);
    return p.mask;
  endfunction

  // Clamp a widened level into the signed DAC_W range.
  function automatic logic [DAC_W-1:0] saturate(input logic signed [EW-1:0] v);
    logic signed [EW-1:0] c;
    c = v;
    if (v > SAT_MAX) c = SAT_MAX;
    if (v < SAT_MIN) c = SAT_MIN;
    return c[DAC_W-1:0];
  endfunction

  // Shadow configuration. The datapath reads only these registers.
  logic [3:0]       pn_sel_q;
  logic [NCO_W-1:0] rate_q;
  logic [3:0]       edge_shift_q;
  logic [DAC_W-1:0] amp_q;
  logic [DAC_W-1:0] dc_q;

  state_t           state;
  logic [NCO_W-1:0] acc;
  logic [LW-1:0]    lfsr;

  poly_t            cur_poly;
  logic [LW-1:0]    seed_mask;
  logic             pn_change;
  logic             lfsr_fb;
  logic [LW-1:0]    lfsr_step;
  logic             nco_carry;
  logic [NCO_W-1:0] nco_sum;

  logic signed [EW-1:0] dc_ext;
  logic signed [EW-1:0] amp_ext;
  logic signed [EW-1:0] tgt_raw;
  logic [DAC_W-1:0]     tgt;
  logic [DAC_W-1:0]     dac_next;

  assign cur_poly  = poly_of(pn_sel_q);
  assign pn_change = cfg_load && (cfg_pn_sel != pn_sel_q);
  // A pn_sel being loaded in the same cycle wins, so the seed length always
  // matches the polynomial that will actually run.
  assign seed_mask = seed_of(cfg_load ? cfg_pn_sel : pn_sel_q);

  assign lfsr_fb   = lfsr[cur_poly.hi] ^ lfsr[cur_poly.lo];
  assign lfsr_step = {lfsr[LW-2:0], lfsr_fb} & cur_poly.mask;

  assign {nco_carry, nco_sum} = {1'b0, acc} + {1'b0, rate_q};

  assign dc_ext  = {{2{dc_q[DAC_W-1]}}, dc_q};
  assign amp_ext = {2'b00, amp_q};

  // Capture the configuration only on a cfg_load pulse.
  always_ff @(posedge dac_clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values no matter how the statements are ordered.
    if (!reset_n) begin
      pn_sel_q     <= '0;
      rate_q       <= '0;
      edge_shift_q <= '0;
      amp_q        <= '0;
      dc_q         <= '0;
    end else if (cfg_load) begin
      pn_sel_q     <= cfg_pn_sel;
      rate_q       <= cfg_rate_inc;
      edge_shift_q <= cfg_edge_shift;
      amp_q        <= cfg_amplitude;
      dc_q         <= cfg_dc_offset;
    end
  end

  // Target level for the current bit: dc +/- amplitude, then saturated.
  always_comb begin
    // NOTE: give every always_comb output a default first, so that no path
    // leaves it unassigned and infers a latch.
    tgt_raw = dc_ext - amp_ext;
    if (prbs_bit) tgt_raw = dc_ext + amp_ext;
  end

  assign tgt = saturate(tgt_raw);

`ifdef PRBS_EDGE_RAMP_EN
  logic [DAC_W:0]       step_raw;
  logic [DAC_W:0]       step_sel;
  logic signed [EW-1:0] step_ext;
  logic signed [EW-1:0] cur_ext;
  logic signed [EW-1:0] tgt_ext;
  logic signed [EW-1:0] diff;
  logic signed [EW-1:0] ramp_ext;

  assign step_raw = {amp_q, 1'b0} >> edge_shift_q;
  assign step_sel = (step_raw == '0) ? {{DAC_W{1'b0}}, 1'b1} : step_raw;
  assign step_ext = {1'b0, step_sel};
  assign cur_ext  = {{2{dac_data[DAC_W-1]}}, dac_data};
  assign tgt_ext  = {{2{tgt[DAC_W-1]}}, tgt};
  assign diff     = tgt_ext - cur_ext;

  // Slew toward the target one step per cycle and land on it exactly. The
  // ramp always starts from the present sample, so a reversal mid-ramp is
  // smooth.
  always_comb begin
    ramp_ext = tgt_ext;
    if (diff > step_ext)       ramp_ext = cur_ext + step_ext;
    else if (diff < -step_ext) ramp_ext = cur_ext - step_ext;
  end

  assign dac_next = saturate(ramp_ext);
`else
  // Without ramping, the output steps to the target in one cycle.
  // The edge_shift shadow register is kept but not used.
  logic unused_edge_shift;
  assign unused_edge_shift = ^edge_shift_q;
  assign dac_next = tgt;
`endif

  // Run/idle control, NCO, LFSR and the registered outputs.
  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      acc        <= '0;
      lfsr       <= 31'h0000_007F;
      prbs_valid <= 1'b0;
      bit_strobe <= 1'b0;
      prbs_bit   <= 1'b0;
      dac_data   <= '0;
    end else begin
      bit_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          acc        <= '0;
          prbs_valid <= 1'b0;
          dac_data   <= dc_q;
          if (enable) begin
            state <= ST_RUN;
            lfsr  <= seed_mask;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state      <= ST_IDLE;
            acc        <= '0;
            prbs_valid <= 1'b0;
            dac_data   <= dc_q;
          end else begin
            // Hold dc until the first bit exists. After that, follow the
            // target set by the bit strobed in the previous cycle.
            dac_data <= prbs_valid ? dac_next : dc_q;
            if (pn_change) begin
              // A new polynomial restarts both the phase and the sequence.
              acc  <= '0;
              lfsr <= seed_mask;
            end else begin
              acc <= nco_sum;
              if (nco_carry) begin
                bit_strobe <= 1'b1;
                prbs_valid <= 1'b1;
                prbs_bit   <= lfsr_fb;
                // All-zeros would lock the LFSR, so reseed if it ever appears.
                lfsr <= (lfsr_step == '0) ? cur_poly.mask : lfsr_step;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_wave_gen.sv
// Directed self-checking bench for prbs_wave_gen. A reference Fibonacci
// LFSR provides the expected bit sequence. Levels and strobe timing are
// hand-derived constants.
module tb_prbs_wave_gen;

  localparam int DAC_W = 16;
  localparam int NCO_W = 32;

  logic             dac_clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             enable = 1'b0;
  logic             cfg_load = 1'b0;
  logic [3:0]       cfg_pn_sel = '0;
  logic [NCO_W-1:0] cfg_rate_inc = '0;
  logic [3:0]       cfg_edge_shift = '0;
  logic [DAC_W-1:0] cfg_amplitude = '0;
  logic [DAC_W-1:0] cfg_dc_offset = '0;
  logic             prbs_valid;
  logic             bit_strobe;
  logic             prbs_bit;
  logic [DAC_W-1:0] dac_data;

  int checks = 0;
  int passes = 0;

  // Reference LFSR state
  logic [30:0] m_state;
  int          m_n;
  int          m_k;
  logic        hist [0:1099];
  logic        mbits[0:1099];

  int tab_n[7] = '{7, 9, 11, 15, 20, 23, 31};
  int tab_k[7] = '{6, 5, 9, 14, 3, 18, 28};

  prbs_wave_gen #(.DAC_W(DAC_W), .NCO_W(NCO_W)) dut (
    .dac_clk(dac_clk), .reset_n(reset_n), .enable(enable), .cfg_load(cfg_load),
    .cfg_pn_sel(cfg_pn_sel), .cfg_rate_inc(cfg_rate_inc),
    .cfg_edge_shift(cfg_edge_shift), .cfg_amplitude(cfg_amplitude),
    .cfg_dc_offset(cfg_dc_offset), .prbs_valid(prbs_valid),
    .bit_strobe(bit_strobe), .prbs_bit(prbs_bit), .dac_data(dac_data)
  );

  always #5 dac_clk = ~dac_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge dac_clk);
    #1;
  endtask

  task automatic model_seed(input int n, input int k);
    m_n = n;
    m_k = k;
    m_state = '0;
    for (int i = 0; i < n; i++) m_state[i] = 1'b1;
  endtask

  // Each output bit is the feedback x^n xor x^k; it is shifted in at bit 0.
  task automatic model_step(output logic b);
    logic fb;
    fb = m_state[m_n-1] ^ m_state[m_k-1];
    m_state = {m_state[29:0], fb};
    if (m_n < 31) m_state[m_n] = 1'b0;
    b = fb;
  endtask

  task automatic load_cfg(input logic [3:0] pn, input logic [31:0] rate,
                          input logic [3:0] shift, input logic [15:0] amp,
                          input logic [15:0] dc);
    cfg_pn_sel = pn; cfg_rate_inc = rate; cfg_edge_shift = shift;
    cfg_amplitude = amp; cfg_dc_offset = dc;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Tick until bit_strobe is seen. gap is the number of ticks, or -1 if the
  // limit expires first.
  task automatic wait_strobe(input int limit, output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!bit_strobe && gap < limit);
    if (!bit_strobe) gap = -1;
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({prbs_valid, bit_strobe, prbs_bit, dac_data} !== 19'h0)
      $display("FAIL reset_async got %h want 0", {prbs_valid, bit_strobe, prbs_bit, dac_data});
    else passes++;
    tick(); tick();
    checks++;
    if ({prbs_valid, bit_strobe, prbs_bit, dac_data} !== 19'h0)
      $display("FAIL reset_held got %h want 0", {prbs_valid, bit_strobe, prbs_bit, dac_data});
    else passes++;
    reset_n = 1'b1;
    tick();
    checks++;
    if ({prbs_valid, dac_data} !== 17'h0)
      $display("FAIL reset_release got %h want 0", {prbs_valid, dac_data});
    else passes++;
  endtask

  task automatic test_idle_dc();
    int strobes;
    load_cfg(4'd0, 32'h0, 4'd0, 16'h1000, 16'h1234);
    tick();
    checks++;
    if (dac_data !== 16'h1234) $display("FAIL idle_dc got %h want 1234", dac_data);
    else passes++;
    // A rate of zero must never strobe. The output stays at dc.
    enable = 1'b1;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bit_strobe) strobes++;
    end
    checks++;
    if (strobes != 0 || prbs_valid !== 1'b0)
      $display("FAIL rate_zero strobes=%0d valid=%b want 0/0", strobes, prbs_valid);
    else passes++;
    checks++;
    if (dac_data !== 16'h1234) $display("FAIL rate_zero_dc got %h want 1234", dac_data);
    else passes++;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_pn7_sequence();
    logic b;
    logic [7:0] first8;
    logic [15:0] exp_lvl;
    load_cfg(4'd0, 32'h8000_0000, 4'd0, 16'h1000, 16'h0100);
    model_seed(7, 6);
    enable = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if (bit_strobe !== (t == 3))
        $display("FAIL pn7_first_strobe t=%0d got %b want %b", t, bit_strobe, (t == 3));
      else passes++;
    end
    checks++;
    if (prbs_valid !== 1'b1) $display("FAIL pn7_valid_rise got %b want 1", prbs_valid);
    else passes++;
    model_step(b);
    mbits[0] = b;
    hist[0] = prbs_bit;
    checks++;
    if (prbs_bit !== b) $display("FAIL pn7_bit0 got %b want %b", prbs_bit, b);
    else passes++;
    for (int i = 1; i < 254; i++) begin
      tick();
      exp_lvl = mbits[i-1] ? 16'h1100 : 16'hF100;
      checks++;
      if ({bit_strobe, dac_data} !== {1'b0, exp_lvl})
        $display("FAIL pn7_gap_dac i=%0d got %b/%h want 0/%h", i, bit_strobe, dac_data, exp_lvl);
      else passes++;
      tick();
      model_step(b);
      mbits[i] = b;
      hist[i] = prbs_bit;
      checks++;
      if ({bit_strobe, prbs_bit} !== {1'b1, b})
        $display("FAIL pn7_bit i=%0d got %b/%b want 1/%b", i, bit_strobe, prbs_bit, b);
      else passes++;
      if (i >= 127) begin
        checks++;
        if (hist[i] !== hist[i-127])
          $display("FAIL pn7_repeat i=%0d got %b want %b", i, hist[i], hist[i-127]);
        else passes++;
      end
    end
    for (int j = 0; j < 8; j++) first8[j] = hist[j];
    checks++;
    if (first8 !== 8'b0100_0000) $display("FAIL pn7_first8 got %b want 01000000", first8);
    else passes++;
  endtask

  task automatic test_idle_return();
    enable = 1'b0;
    tick();
    checks++;
    if ({prbs_valid, bit_strobe, dac_data} !== {2'b00, 16'h0100})
      $display("FAIL idle_return got %b/%b/%h want 0/0/0100", prbs_valid, bit_strobe, dac_data);
    else passes++;
  endtask

  task automatic test_pn_periods();
    int sels[8] = '{0, 1, 2, 3, 4, 5, 6, 9};
    int mi, n, len, per, ones, early;
    logic b;
    for (int s = 0; s < 8; s++) begin
      mi = (sels[s] <= 6) ? sels[s] : 0;
      n = tab_n[mi];
      len = (n == 7) ? 254 : (n == 9) ? 1022 : 200;
      per = (1 << n) - 1;
      enable = 1'b0;
      tick();
      load_cfg(4'(sels[s]), 32'hFFFF_FFFF, 4'd0, 16'h1000, 16'h0000);
      model_seed(n, tab_k[mi]);
      enable = 1'b1;
      early = 0;
      tick(); if (bit_strobe) early++;
      tick(); if (bit_strobe) early++;
      checks++;
      if (early != 0) $display("FAIL pn_first_cycle sel=%0d got %0d strobes want 0", sels[s], early);
      else passes++;
      ones = 0;
      for (int j = 0; j < len; j++) begin
        tick();
        model_step(b);
        hist[j] = prbs_bit;
        if (prbs_bit === 1'b1) ones++;
        checks++;
        if ({bit_strobe, prbs_bit} !== {1'b1, b})
          $display("FAIL pn_bit sel=%0d j=%0d got %b/%b want 1/%b", sels[s], j, bit_strobe, prbs_bit, b);
        else passes++;
        if (n <= 9 && j >= per) begin
          checks++;
          if (hist[j] !== hist[j-per])
            $display("FAIL pn_period sel=%0d j=%0d got %b want %b", sels[s], j, hist[j], hist[j-per]);
          else passes++;
        end
      end
      checks++;
      if (ones == 0) $display("FAIL pn_zero_lock sel=%0d got 0 ones want >0", sels[s]);
      else passes++;
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    logic b, prev;
    logic [15:0] exp_lvl;
    load_cfg(4'd0, 32'hFFFF_FFFF, 4'd0, 16'h7000, 16'h3000);
    model_seed(7, 6);
    enable = 1'b1;
    tick(); tick();
    prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_lvl = (i == 0) ? 16'h3000 : (prev ? 16'h7FFF : 16'hC000);
      model_step(b);
      checks++;
      if ({prbs_bit, dac_data} !== {b, exp_lvl})
        $display("FAIL saturation i=%0d got %b/%h want %b/%h", i, prbs_bit, dac_data, b, exp_lvl);
      else passes++;
      prev = b;
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_edge_ramp();
    int gap, exp;
    logic b;
    load_cfg(4'd0, 32'h0800_0000, 4'd4, 16'h1000, 16'h0000);
    model_seed(7, 6);
    enable = 1'b1;
    for (int s = 0; s < 7; s++) begin
      wait_strobe(40, gap);
      model_step(b);
      checks++;
      if (gap != ((s == 0) ? 33 : 32) || prbs_bit !== b)
        $display("FAIL ramp_strobe s=%0d got gap %0d bit %b want %0d/%b", s, gap, prbs_bit,
                 (s == 0) ? 33 : 32, b);
      else passes++;
    end
    checks++;
    if (dac_data !== 16'hF000) $display("FAIL ramp_start got %h want f000", dac_data);
    else passes++;
    for (int k = 1; k <= 17; k++) begin
      tick();
`ifdef PRBS_EDGE_RAMP_EN
      exp = -4096 + 512 * k;
      if (exp > 4096) exp = 4096;
`else
      exp = 4096;
`endif
      checks++;
      if (dac_data !== 16'(exp)) $display("FAIL ramp_step k=%0d got %h want %h", k, dac_data, 16'(exp));
      else passes++;
    end
  endtask

  task automatic test_reset_mid_ramp();
    int gap;
    logic b;
    wait_strobe(40, gap);
    model_step(b);
    checks++;
    if (gap != 15 || prbs_bit !== b)
      $display("FAIL ramp_down_strobe got gap %0d bit %b want 15/%b", gap, prbs_bit, b);
    else passes++;
    tick(); tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({prbs_valid, bit_strobe, prbs_bit, dac_data} !== 19'h0)
      $display("FAIL reset_mid_run got %h want 0", {prbs_valid, bit_strobe, prbs_bit, dac_data});
    else passes++;
    enable = 1'b0;
    tick(); tick();
    checks++;
    if ({prbs_valid, bit_strobe, prbs_bit, dac_data} !== 19'h0)
      $display("FAIL reset_enable_toggle got %h want 0", {prbs_valid, bit_strobe, prbs_bit, dac_data});
    else passes++;
    reset_n = 1'b1;
    tick();
    checks++;
    if ({prbs_valid, dac_data} !== 17'h0)
      $display("FAIL post_reset_idle got %h want 0", {prbs_valid, dac_data});
    else passes++;
    load_cfg(4'd0, 32'h0, 4'd0, 16'h0000, 16'h0ABC);
    tick();
    checks++;
    if ({prbs_valid, bit_strobe, dac_data} !== {2'b00, 16'h0ABC})
      $display("FAIL post_reset_dc got %b/%b/%h want 0/0/0abc", prbs_valid, bit_strobe, dac_data);
    else passes++;
  endtask

  task automatic test_rate_change();
    int gap;
    logic b;
    load_cfg(4'd0, 32'h8000_0000, 4'd0, 16'h1000, 16'h0000);
    model_seed(7, 6);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_strobe(10, gap);
      model_step(b);
      checks++;
      if (gap != ((i == 0) ? 3 : 2) || prbs_bit !== b)
        $display("FAIL rate_before i=%0d got gap %0d bit %b want %0d/%b", i, gap, prbs_bit,
                 (i == 0) ? 3 : 2, b);
      else passes++;
    end
    // Load a half rate right after a strobe. The accumulator keeps its phase,
    // so the next carry comes 3 cycles after that strobe, then every 4 cycles.
    load_cfg(4'd0, 32'h4000_0000, 4'd0, 16'h1000, 16'h0000);
    checks++;
    if (bit_strobe !== 1'b0) $display("FAIL rate_load_cycle got %b want 0", bit_strobe);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(10, gap);
      model_step(b);
      checks++;
      if (gap != ((i == 0) ? 2 : 4) || prbs_bit !== b)
        $display("FAIL rate_after i=%0d got gap %0d bit %b want %0d/%b", i, gap, prbs_bit,
                 (i == 0) ? 2 : 4, b);
      else passes++;
    end
    enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_dc();
    test_pn7_sequence();
    test_idle_return();
    test_pn_periods();
    test_saturation();
    test_edge_ramp();
    test_reset_mid_ramp();
    test_rate_change();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/prbs_wave_gen.md
PRBS_WAVE_GEN -- requirements
Module: prbs_wave_gen

Interface
REQ-001 Parameters SHALL be:
- DAC_W, default 16: DAC sample width.
- NCO_W, default 32: bit-rate accumulator width.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset. Ports are listed below as name, direction, width, meaning.
REQ-003 dac_clk  in  1  sole clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 enable  in  1  0 = IDLE (DC output), 1 = generate PRBS.
REQ-006 cfg_load  in  1  one-cycle pulse that captures all cfg_* inputs into shadow registers.
REQ-007 cfg_pn_sel  in  4  PN order select.
REQ-008 cfg_rate_inc  in  NCO_W  bit-rate phase increment.
REQ-009 cfg_edge_shift  in  4  edge ramp length, 2^n cycles.
REQ-010 cfg_amplitude  in  DAC_W  unsigned swing about offset.
REQ-011 cfg_dc_offset  in  DAC_W  signed DC level.
REQ-012 prbs_valid  out  1  high once the first bit has been emitted in RUN.
REQ-013 bit_strobe  out  1  one-cycle pulse per new PRBS bit.
REQ-014 prbs_bit  out  1  current PRBS bit.
REQ-015 dac_data  out  DAC_W  signed two's-complement sample.

Function
REQ-016 Shadow registers SHALL update only on cfg_load; the datapath SHALL use only shadow values.
REQ-017 cfg_pn_sel mapping (polynomial, Fibonacci LFSR):
- 0 = PN7 x^7+x^6+1
- 1 = PN9 x^9+x^5+1
- 2 = PN11 x^11+x^9+1
- 3 = PN15 x^15+x^14+1
- 4 = PN20 x^20+x^3+1
- 5 = PN23 x^23+x^18+1
- 6 = PN31 x^31+x^28+1
- 7-15 = PN7
REQ-018 Seeding: the LFSR SHALL be seeded to all-ones over the active length on enable rising and on any cfg_load that changes pn_sel; it SHALL never hold all-zeros.
REQ-019 State machine SHALL have two states, IDLE and RUN.
- IDLE→RUN: enable=1.
- RUN→IDLE: enable=0, taking effect next cycle.
REQ-020 NCO: in RUN, acc <= acc + rate_inc (mod 2^NCO_W) each cycle; a carry-out SHALL assert bit_strobe and advance the LFSR in the same cycle.
REQ-021 prbs_bit SHALL show the new LFSR output in the cycle bit_strobe is high.
REQ-022 rate_inc=0 SHALL produce no strobes; rate_inc=2^NCO_W-1 SHALL strobe every cycle except the first.
REQ-023 prbs_valid SHALL rise with the first bit_strobe after entering RUN and fall in IDLE.
REQ-024 Target level SHALL be dc_offset+amplitude for bit 1 and dc_offset-amplitude for bit 0, computed at DAC_W+2 bits and saturated to the signed DAC_W range.
REQ-025 dac_data SHALL move toward a new target starting the cycle after bit_strobe (1-cycle latency).
REQ-026 In IDLE, acc SHALL be 0 and dac_data SHALL equal saturated dc_offset.
REQ-027 A cfg_load mid-RUN SHALL take effect on the next cycle without resetting acc unless pn_sel changed.

Reset
REQ-028 While reset_n=0:
- state IDLE, acc 0, LFSR all-ones;
- shadows: pn_sel 0, rate_inc 0, edge_shift 0, amplitude 0, dc_offset 0;
- prbs_valid 0, bit_strobe 0, prbs_bit 0, dac_data 0.
REQ-029 Deassertion SHALL be followed by normal operation on the next edge; reset mid-RUN SHALL abort immediately to IDLE values.

Configuration
REQ-030 Macro PRBS_EDGE_RAMP_EN defined:
- dac_data steps toward target by step = max(1, (2*amplitude)>>edge_shift) each cycle;
- it clamps exactly at target with no overshoot;
- a bit change mid-ramp reverses from the current value;
- edge_shift=0 gives a single-cycle step.
REQ-031 Macro undefined: dac_data SHALL jump to target in one cycle and edge_shift SHALL be stored but ignored.

Verification
REQ-032 PN7, rate_inc=2^31, enable=1 → bit_strobe every 2 cycles; first 127 bits match reference LFSR; sequence repeats at bit 128.
REQ-033 Each pn_sel 0-6 with rate_inc=all-ones → period 2^N-1 and no all-zero lock; pn_sel=9 behaves as PN7.
REQ-034 amplitude=0x7000, dc_offset=0x3000 → high output 0x7FFF (saturated), low output 0xC000.
REQ-035 Macro on, amplitude=0x1000, edge_shift=4, bit 0→1 → 16 cycles of +0x200 steps from 0xF000 to 0x1000 exactly.
REQ-036 reset_n dropped mid-ramp, then enable toggled 1→0 → all outputs 0 asynchronously; after release in IDLE, dac_data equals dc_offset.
REQ-037 cfg_load changing rate_inc only, mid-RUN → strobe spacing changes next cycle, PRBS sequence continues unbroken.
